// File: rtl/multi_edge_pkg.sv
// Shared encodings for the multi-channel debounced edge detector.
// Holds the channel FSM state codes, the edge-select mode codes and a mode decode helper.
package multi_edge_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE_LOW     = 2'd0;
  localparam logic [1:0] ST_CONFIRM_HIGH = 2'd1;
  localparam logic [1:0] ST_IDLE_HIGH    = 2'd2;
  localparam logic [1:0] ST_CONFIRM_LOW  = 2'd3;

  typedef enum logic [1:0] {
    IDLE_LOW     = ST_IDLE_LOW,
    CONFIRM_HIGH = ST_CONFIRM_HIGH,
    IDLE_HIGH    = ST_IDLE_HIGH,
    CONFIRM_LOW  = ST_CONFIRM_LOW
  } state_e;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // True when the mode code enables the given edge direction.
  function automatic logic edge_enabled(input logic [1:0] mode, input logic rising);
    if (rising) return (mode == MODE_RISE) || (mode == MODE_BOTH);
    else        return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel: input synchroniser, tick-gated debounce FSM with counter,
// edge pulse generation and sticky pending flag.
module edge_channel
  import multi_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       signal,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       outedge,
  output logic       pending
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d, count_inc;
  logic                   level_d, outedge_d, pending_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      count_q <= '0;
      level   <= 1'b0;
      outedge <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], signal};
      state_q <= state_d;
      count_q <= count_d;
      level   <= level_d;
      outedge <= outedge_d;
      pending <= pending_d;
    end
  end

  // Debounce: a level change is accepted after DEB consecutive ticks at the new value.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    count_inc = count_q + CNT_W'(1);
    if (sample_tick) begin
      case (state_q)
        IDLE_LOW: begin
          if (sync_bit) begin
            count_d = CNT_W'(1);
            state_d = (DEB == CNT_W'(1)) ? IDLE_HIGH : CONFIRM_HIGH;
          end
        end
        CONFIRM_HIGH: begin
          if (!sync_bit) begin
            state_d = IDLE_LOW;
            count_d = '0;
          end else if (count_inc == DEB) begin
            state_d = IDLE_HIGH;
            count_d = '0;
          end else begin
            count_d = count_inc;
          end
        end
        IDLE_HIGH: begin
          if (!sync_bit) begin
            count_d = CNT_W'(1);
            state_d = (DEB == CNT_W'(1)) ? IDLE_LOW : CONFIRM_LOW;
          end
        end
        CONFIRM_LOW: begin
          if (sync_bit) begin
            state_d = IDLE_HIGH;
            count_d = '0;
          end else if (count_inc == DEB) begin
            state_d = IDLE_LOW;
            count_d = '0;
          end else begin
            count_d = count_inc;
          end
        end
        default: begin
          state_d = IDLE_LOW;
          count_d = '0;
        end
      endcase
    end

    level_d   = (state_d == IDLE_HIGH) || (state_d == CONFIRM_LOW);
    outedge_d = (level_d && !level && edge_enabled(mode, 1'b1)) ||
                (!level_d && level && edge_enabled(mode, 1'b0));
    // A visible pulse outranks a concurrent clear.
    pending_d = outedge || (pending && !clr);
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector: one edge_channel per input bit
// plus a registered OR of all pending flags.
module multi_edge_detector
  import multi_edge_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   outedge,
  output logic [CHANNELS-1:0]   pending,
  output logic                  any_pending
);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick),
      .signal      (signal[i]),
      .mode        (mode[2*i +: 2]),
      .clr         (clr[i]),
      .level       (level[i]),
      .outedge     (outedge[i]),
      .pending     (pending[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) any_pending <= 1'b0;
    else        any_pending <= |pending;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: directed stimulus queues expected
// edge pulses; a monitor pops and compares whenever outedge is non-zero.
module tb_multi_edge_detector;

  logic       clk;
  logic       reset;
  logic       sample_tick;
  logic [3:0] signal;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] level;
  logic [3:0] outedge;
  logic [3:0] pending;
  logic       any_pending;

  typedef struct {
    logic [3:0] oe;
    logic [3:0] lvl;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   failures;

  multi_edge_detector #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .signal      (signal),
    .mode        (mode),
    .clr         (clr),
    .level       (level),
    .outedge     (outedge),
    .pending     (pending),
    .any_pending (any_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every non-zero outedge must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (outedge !== 4'b0000) begin
        if (sb.size() == 0) begin
          checks   = checks + 1;
          failures = failures + 1;
          $display("FAIL unexpected_outedge actual=%b expected=none (cycle %0d)", outedge, cyc);
        end else begin
          e = sb.pop_front();
          chk("outedge_vec",   32'(outedge), 32'(e.oe));
          chk("outedge_cycle", 32'(cyc),     32'(e.cyc));
          chk("outedge_level", 32'(level),   32'(e.lvl));
        end
      end
    end
  end

  initial begin
    int c;
    int r;
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    sample_tick = 1'b1;
    signal      = 4'b0000;
    mode        = 8'h55;
    clr         = 4'b0000;

    step(3);
    chk("rst_level",   32'(level),       32'h0);
    chk("rst_outedge", 32'(outedge),     32'h0);
    chk("rst_pending", 32'(pending),     32'h0);
    chk("rst_any",     32'(any_pending), 32'h0);
    reset = 1'b1;
    step(8);
    chk("idle_level", 32'(level), 32'h0);

    // Clean rising edge on channel 0, six-edge latency
    c = cyc;
    signal[0] = 1'b1;
    sb.push_back('{oe: 4'b0001, lvl: 4'b0001, cyc: c + 6});
    step(5);
    chk("rise0_early_level", 32'(level), 32'h0);
    step(1);
    chk("rise0_level",   32'(level),   32'h1);
    chk("rise0_pending", 32'(pending), 32'h0);
    step(1);
    chk("rise0_pulse_end", 32'(outedge),     32'h0);
    chk("rise0_pending_1", 32'(pending),     32'h1);
    chk("rise0_any_lag",   32'(any_pending), 32'h0);
    step(1);
    chk("rise0_any", 32'(any_pending), 32'h1);
    clr = 4'b0001;
    step(1);
    chk("clr0_pending", 32'(pending),     32'h0);
    chk("clr0_any_lag", 32'(any_pending), 32'h1);
    clr = 4'b0000;
    step(1);
    chk("clr0_any", 32'(any_pending), 32'h0);

    // Three-sample glitch on channel 1 must be rejected
    mode = 8'h6D;
    signal[1] = 1'b1;
    step(3);
    signal[1] = 1'b0;
    step(10);
    chk("glitch1_level", 32'(level), 32'h1);

    // Channel 2 falling-only: level follows both, pulse only on fall
    c = cyc;
    signal[2] = 1'b1;
    step(6);
    chk("ch2_rise_level", 32'(level), 32'h5);
    c = cyc;
    signal[2] = 1'b0;
    sb.push_back('{oe: 4'b0100, lvl: 4'b0001, cyc: c + 6});
    step(5);
    chk("ch2_fall_early", 32'(level), 32'h5);
    step(1);
    chk("ch2_fall_level", 32'(level), 32'h1);
    step(2);

    // Channel 3 with a tick every fourth clock: rises on the fourth tick
    c = cyc;
    signal[3] = 1'b1;
    sb.push_back('{oe: 4'b1000, lvl: 4'b1001, cyc: c + 16});
    for (int k = 0; k < 20; k++) begin
      sample_tick = ((k % 4) == 3);
      step(1);
      if (k == 14) chk("tick3_early_level", 32'(level), 32'h1);
      if (k == 15) chk("tick3_level",       32'(level), 32'h9);
    end
    sample_tick = 1'b1;

    // Clear coinciding with a pulse loses; clear one cycle later wins
    mode = 8'h6F;
    step(1);
    c = cyc;
    signal[0] = 1'b0;
    sb.push_back('{oe: 4'b0001, lvl: 4'b1000, cyc: c + 6});
    step(6);
    chk("fall0_outedge", 32'(outedge), 32'h1);
    clr = 4'b0001;
    step(1);
    chk("clr_vs_edge_pending0", 32'(pending[0]), 32'h1);
    step(1);
    chk("clr_after_pending0", 32'(pending[0]), 32'h0);
    clr = 4'b0000;

    // Reset mid-confirmation, then full re-debounce of the high inputs
    signal[1] = 1'b1;
    step(4);
    reset = 1'b0;
    #1;
    chk("mid_rst_level",   32'(level),       32'h0);
    chk("mid_rst_outedge", 32'(outedge),     32'h0);
    chk("mid_rst_pending", 32'(pending),     32'h0);
    chk("mid_rst_any",     32'(any_pending), 32'h0);
    step(2);
    reset = 1'b1;
    r = cyc;
    sb.push_back('{oe: 4'b1010, lvl: 4'b1010, cyc: r + 6});
    step(5);
    chk("post_rst_early_level", 32'(level), 32'h0);
    step(1);
    chk("post_rst_level", 32'(level), 32'hA);
    step(2);
    chk("post_rst_pending", 32'(pending), 32'hA);
    clr = 4'b1111;
    step(1);
    clr = 4'b0000;
    step(2);
    chk("final_pending", 32'(pending),     32'h0);
    chk("final_any",     32'(any_pending), 32'h0);
    step(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
